// File: rtl/icache_assoc_pkg.sv
// Shared types and parameter-derived field widths for the set-associative icache.
package icache_assoc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int boff_w(input int blkwords);
    return $clog2(blkwords);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int blkwords);
    return 30 - boff_w(blkwords) - idx_w(sets);
  endfunction

  // Zero-width fields are carried as one bit that is tied to 0.
  function automatic int min1(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid/tag plus BLKWORDS data words per set.
// Combinational read port, single-word fill write port, whole-way flush.
module icache_way #(
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2,
  parameter int TAGW     = 26,
  parameter int IDXW     = 3,
  parameter int BOFFW    = 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [IDXW-1:0]  rd_idx_i,
  input  logic [BOFFW-1:0] rd_boff_i,
  output logic             valid_o,
  output logic [TAGW-1:0]  tag_o,
  output logic [31:0]      data_o,
  input  logic [IDXW-1:0]  wr_idx_i,
  input  logic [BOFFW-1:0] wr_boff_i,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_en_i,
  input  logic [IDXW-1:0]  inv_idx_i,
  input  logic             inv_en_i,
  input  logic             set_en_i,
  input  logic [TAGW-1:0]  set_tag_i,
  input  logic             flush_i
);

  localparam int DW = $clog2(SETS * BLKWORDS);

  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS*BLKWORDS];
  logic [DW-1:0]   rd_a;
  logic [DW-1:0]   wr_a;

  assign rd_a = DW'(rd_idx_i) * DW'(BLKWORDS) + DW'(rd_boff_i);
  assign wr_a = DW'(wr_idx_i) * DW'(BLKWORDS) + DW'(wr_boff_i);

  assign valid_o = valid_q[rd_idx_i];
  assign tag_o   = tag_q[rd_idx_i];
  assign data_o  = data_q[rd_a];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (inv_en_i) begin
      valid_q[inv_idx_i] <= 1'b0;
    end else if (set_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge CLK) begin
    if (set_en_i && !flush_i) tag_q[wr_idx_i] <= set_tag_i;
    if (wr_en_i) data_q[wr_a] <= wr_data_i;
  end

endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative, block-fill instruction cache with round-robin
// replacement and flush. Define ICACHE_STATS_EN to add hitcnt/misscnt outputs.
//   state | meaning
//   IDLE  | serve hits combinationally; a miss latches address and picks a victim
//   FILL  | fetch the block word by word under iwait; flush aborts
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt
`endif
);

  localparam int BOFF  = boff_w(BLKWORDS);
  localparam int IDXW  = idx_w(SETS);
  localparam int TAGW  = tag_w(SETS, BLKWORDS);
  localparam int BOFFW = min1(BOFF);
  localparam int WAYW  = min1($clog2(WAYS));
  localparam logic [BOFFW-1:0] LAST_WORD = BOFFW'(BLKWORDS - 1);

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [IDXW-1:0]  idx;
    logic [BOFFW-1:0] boff;
  } word_addr_t;

  word_addr_t       req;
  logic [31:0]      fill_addr;
  logic             unused_bits;

  state_t           state_q, state_d;
  logic [BOFFW-1:0] cnt_q, cnt_d;
  logic [TAGW-1:0]  miss_tag_q, miss_tag_d;
  logic [IDXW-1:0]  miss_idx_q, miss_idx_d;
  logic [WAYW-1:0]  victim_q, victim_d, victim_sel;
  logic [WAYW-1:0]  ptr_q [SETS];

  logic             start_fill, fill_we, fill_done;
  logic [WAYS-1:0]  way_valid, way_match;
  logic [TAGW-1:0]  way_tag  [WAYS];
  logic [31:0]      way_data [WAYS];
  logic             hit_any;

  assign unused_bits = ^imemaddr[1:0];

  if (BOFF > 0) begin : g_blk
    assign req       = imemaddr[31:2];
    assign fill_addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
  end else begin : g_word
    assign req       = {imemaddr[31:2], 1'b0};
    assign fill_addr = {miss_tag_q, miss_idx_q, 2'b00};
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS    (SETS),
      .BLKWORDS(BLKWORDS),
      .TAGW    (TAGW),
      .IDXW    (IDXW),
      .BOFFW   (BOFFW)
    ) u_way (
      .CLK      (CLK),
      .nRST     (nRST),
      .rd_idx_i (req.idx),
      .rd_boff_i(req.boff),
      .valid_o  (way_valid[w]),
      .tag_o    (way_tag[w]),
      .data_o   (way_data[w]),
      .wr_idx_i (miss_idx_q),
      .wr_boff_i(cnt_q),
      .wr_data_i(iload),
      .wr_en_i  (fill_we && (victim_q == WAYW'(w))),
      .inv_idx_i(req.idx),
      .inv_en_i (start_fill && (victim_sel == WAYW'(w))),
      .set_en_i (fill_done && (victim_q == WAYW'(w))),
      .set_tag_i(miss_tag_q),
      .flush_i  (iflush)
    );
    assign way_match[w] = way_valid[w] && (way_tag[w] == req.tag);
  end

  assign hit_any = |way_match;
  assign ihit    = (state_q == IDLE) && imemREN && hit_any && !iflush;

  always_comb begin
    imemload = '0;
    if (ihit) begin
      for (int w = 0; w < WAYS; w++) begin
        if (way_match[w]) imemload = imemload | way_data[w];
      end
    end
  end

  // Lowest invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    victim_sel = ptr_q[req.idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_sel = WAYW'(w);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    victim_d   = victim_q;
    start_fill = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit_any && !iflush) begin
          state_d    = FILL;
          start_fill = 1'b1;
          cnt_d      = '0;
          miss_tag_d = req.tag;
          miss_idx_d = req.idx;
          victim_d   = victim_sel;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_addr;
        if (iflush) begin
          state_d = IDLE;
        end else if (!iwait) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + BOFFW'(1);
          if (cnt_q == LAST_WORD) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      victim_q   <= victim_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else if (iflush) begin
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else if (fill_done) begin
      ptr_q[miss_idx_q] <= (ptr_q[miss_idx_q] == WAYW'(WAYS - 1)) ? '0
                                                                  : ptr_q[miss_idx_q] + WAYW'(1);
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hitcnt_q, misscnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitcnt_q  <= '0;
      misscnt_q <= '0;
    end else if (iflush) begin
      hitcnt_q  <= '0;
      misscnt_q <= '0;
    end else begin
      if (ihit)       hitcnt_q  <= hitcnt_q + 32'd1;
      if (start_fill) misscnt_q <= misscnt_q + 32'd1;
    end
  end

  assign hitcnt  = hitcnt_q;
  assign misscnt = misscnt_q;
`endif

endmodule
